muxn_rr: RTL and testbench
==========================

MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 SHALL provide parameter N, default 4: number of input channels, legal range 2..16, power of two not required.
REQ-002 SHALL provide parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 SHALL provide parameter SW, default 2: select/channel-index width, equal to ceil(log2(N)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = fixed select by sel; 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used when mode=0.
REQ-008 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-009 in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-010 in_ready  output  N  per-channel accept strobe; combinational.
REQ-011 out_valid  output  1  registered output holds a word.
REQ-012 out_data  output  W  registered output word.
REQ-013 out_ch  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts the word on a cycle where out_valid=1.
REQ-015 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-016 load SHALL equal (out_valid=0) OR (out_ready=1); a transfer on channel i SHALL occur on a cycle where in_valid[i]=1 and in_ready[i]=1.
REQ-017 in_ready SHALL be one-hot or all-zero; in_ready[i]=1 SHALL hold only when load=1, in_valid[i]=1, and channel i is granted.
REQ-018 Grant for mode=0: channel sel if in_valid[sel]=1; no grant if sel>=N or in_valid[sel]=0.
REQ-019 Grant for mode=1: the first channel with in_valid=1, searched upward from rr_ptr with wrap from N-1 to 0.
REQ-020 rr_ptr (internal, SW bits) SHALL become (granted index+1) mod N on every accepted transfer in either mode; with no accept it SHALL hold.
REQ-021 On accept, the next edge SHALL set out_valid=1, out_data=selected in_data slice, and out_ch=granted index: latency 1 cycle.
REQ-022 If load=1 and there is no grant, the next edge SHALL clear out_valid; out_data and out_ch SHALL hold their previous values.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ch SHALL remain stable and every in_ready bit SHALL be 0.
REQ-024 A simultaneous output drain and new accept SHALL sustain 1 word per cycle with no bubble.
REQ-025 A change to mode or sel SHALL affect only grants from that cycle on; a registered word already held SHALL be unaffected.
REQ-026 xfer_cnt SHALL increment on each cycle where out_valid=1 and out_ready=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-027 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_ch=0, rr_ptr=0, and xfer_cnt=0, independent of clk.
REQ-028 During reset, in_ready SHALL be all-zero.
REQ-029 A word held in the output register when reset asserts SHALL be discarded and not counted.
REQ-030 After reset deasserts, the first accept is allowed on the first rising edge at which rst_n=1.

Configuration
REQ-031 Macro MUXN_RR_XFER_CNT_EN defined: xfer_cnt SHALL behave as in REQ-026.
REQ-032 Macro MUXN_RR_XFER_CNT_EN undefined: the counter SHALL not be built, and the xfer_cnt port SHALL remain present and be driven constant 0.

Verification
REQ-033 Fixed-select sweep: mode=0, out_ready=1, N=4, W=8, in_valid=4'b1111, in_data={8'h08,8'h04,8'h02,8'h01}, sel=0,1,2,3 on successive cycles -> out_data=01,02,04,08 with out_ch=0,1,2,3, each 1 cycle after its sel.
REQ-034 Round-robin fairness: mode=1, all channels valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and xfer_cnt=8.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles after an accept -> out_data stable, in_ready=0, then one transfer on release with no loss or duplicate.
REQ-036 Sparse wrap: mode=1, rr_ptr=3, only in_valid[1]=1 -> grant channel 1 and next rr_ptr=2; with sel=3'd5 at N=5... covered by a separate N=5 run with mode=0 and sel=7 -> no grant.
REQ-037 Reset mid-operation: assert rst_n=0 between edges while out_valid=1 -> outputs zero immediately; with the macro undefined, xfer_cnt stays 0 throughout.

Source files
------------

// File: rtl/muxn_rr.sv
// muxn_rr: N-channel input mux with fixed-select or round-robin grant,
// feeding a single registered output stage with valid/ready handshake.
// Optional transfer counter is built only when MUXN_RR_XFER_CNT_EN is defined;
// otherwise xfer_cnt is tied to zero.

// Per-channel ready strobe: a channel is accepted only when it is the granted one.
module muxn_rr_lane #(
    parameter int SW  = 2,
    parameter int IDX = 0
) (
    input  logic          en,
    input  logic          req,
    input  logic          gnt_vld,
    input  logic [SW-1:0] gnt_idx,
    output logic          rdy
);
    assign rdy = en & req & gnt_vld & (gnt_idx == SW'(IDX));
endmodule

module muxn_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready,
    output logic [15:0]     xfer_cnt
);
    logic [N-1:0][W-1:0] din;
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       gnt_idx, hi_idx, lo_idx;
    logic                gnt_vld, hi_vld, lo_vld;
    logic                load, accept;

    assign din    = in_data;
    // Output register can take a word when empty or being drained this cycle.
    assign load   = ~out_valid | out_ready;
    assign accept = |in_ready;

    // Grant selection: fixed index in mode 0; in mode 1 the lowest requester at
    // or above rr_ptr wins, falling back to the lowest requester overall (wrap).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        hi_vld  = 1'b0;
        hi_idx  = '0;
        lo_vld  = 1'b0;
        lo_idx  = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && sel == SW'(i)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    lo_vld = 1'b1;
                    lo_idx = SW'(i);
                    if (i >= int'(rr_ptr)) begin
                        hi_vld = 1'b1;
                        hi_idx = SW'(i);
                    end
                end
            end
            gnt_vld = hi_vld | lo_vld;
            gnt_idx = hi_vld ? hi_idx : lo_idx;
        end
    end

    // One ready lane per channel; reset forces every strobe low.
    for (genvar i = 0; i < N; i++) begin : g_lane
        muxn_rr_lane #(.SW(SW), .IDX(i)) u_lane (
            .en      (load & rst_n),
            .req     (in_valid[i]),
            .gnt_vld (gnt_vld),
            .gnt_idx (gnt_idx),
            .rdy     (in_ready[i])
        );
    end

    // Output register and round-robin pointer; data/channel hold when no accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load) out_valid <= gnt_vld;
            if (accept) begin
                out_data <= din[gnt_idx];
                out_ch   <= gnt_idx;
                rr_ptr   <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef MUXN_RR_XFER_CNT_EN
    // Saturating count of words handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xfer_cnt <= '0;
        else if (out_valid && out_ready && xfer_cnt != 16'hFFFF)
            xfer_cnt <= xfer_cnt + 16'd1;
    end
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: reference model checked every cycle plus directed literals.
module tb_muxn_rr;
    localparam int N = 4, W = 8, SW = 2;
    localparam int N5 = 5, SW5 = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = {8'h08, 8'h04, 8'h02, 8'h01};
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready = 1'b1;
    logic [15:0]    xfer_cnt;

    logic            mode5 = 1'b0;
    logic [SW5-1:0]  sel5 = 3'd7;
    logic [N5-1:0]   in_valid5 = 5'b11111;
    logic [N5*W-1:0] in_data5 = {8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
    logic [N5-1:0]   in_ready5;
    logic            out_valid5;
    logic [W-1:0]    out_data5;
    logic [SW5-1:0]  out_ch5;
    logic [15:0]     xfer_cnt5;

    int errs = 0;
    int checks = 0;

    muxn_rr #(.N(N), .W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .xfer_cnt(xfer_cnt));

    muxn_rr #(.N(N5), .W(W), .SW(SW5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_valid(in_valid5),
        .in_data(in_data5), .in_ready(in_ready5), .out_valid(out_valid5),
        .out_data(out_data5), .out_ch(out_ch5), .out_ready(1'b1), .xfer_cnt(xfer_cnt5));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: output register contents, pointer and count.
    logic        m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int          m_ch = 0;
    int          m_rr = 0;
    int          m_cnt = 0;

    // Who wins: fixed sel, or walk upward from rr modulo N.
    function automatic int mgrant(input logic md, input int s, input logic [N-1:0] v, input int rr);
        if (!md) begin
            if (s < N) begin
                if (v[s]) return s;
            end
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        int g;
        if (!rst_n) return '0;
        g = mgrant(mode, int'(sel), in_valid, m_rr);
        if (g < 0 || !(!m_valid || out_ready)) return '0;
        return N'(1 << g);
    endfunction

    // Model update on each edge, cleared by async reset.
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid <= 1'b0; m_data <= '0; m_ch <= 0; m_rr <= 0; m_cnt <= 0;
        end else begin
            g = mgrant(mode, int'(sel), in_valid, m_rr);
`ifdef MUXN_RR_XFER_CNT_EN
            if (m_valid && out_ready && m_cnt < 65535) m_cnt <= m_cnt + 1;
`endif
            if (!m_valid || out_ready) begin
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data[g*W +: W];
                    m_ch    <= g;
                    m_rr    <= (g + 1) % N;
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        chk("m_in_ready", in_ready, exp_rdy());
        chk("m_out_valid", out_valid, m_valid);
        chk("m_out_data", out_data, m_data);
        chk("m_out_ch", out_ch, m_ch);
        chk("m_xfer_cnt", xfer_cnt, m_cnt);
    end

    int cnt8, cnt9;

    initial begin
`ifdef MUXN_RR_XFER_CNT_EN
        cnt8 = 8; cnt9 = 9;
`else
        cnt8 = 0; cnt9 = 0;
`endif
        // Reset with requests pending: no readies, outputs zero.
        mode = 1'b1; in_valid = 4'b1111;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        step();
        rst_n = 1'b1;

        // Fixed-select sweep.
        mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = SW'(k);
            step();
            chk("sweep_data", out_data, 64'(1 << k));
            chk("sweep_ch", out_ch, k);
        end

        // Reset between edges while holding a word.
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_ch", out_ch, 0);
        chk("midrst_cnt", xfer_cnt, 0);
        chk("midrst_ready", in_ready, 0);
        #1 rst_n = 1'b1;

        // Round-robin fairness, full throughput.
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_ch", out_ch, k % 4);
            chk("rr_data", out_data, 64'(1 << (k % 4)));
            chk("rr_valid", out_valid, 1);
        end
        in_valid = '0;
        step();
        chk("rr_drain_valid", out_valid, 0);
        chk("rr_hold_ch", out_ch, 3);
        chk("rr_cnt", xfer_cnt, cnt8);

        // Backpressure: one word held for three cycles.
        in_valid = 4'b0010;
        step();
        chk("bp_first", out_data, 8'h02);
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_data", out_data, 8'h02);
            chk("bp_ch", out_ch, 1);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = '0;
        step();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_cnt", xfer_cnt, cnt9);

        // Sparse wrap: ptr to 3, then only ch1 requests.
        in_valid = 4'b0100;
        step();
        chk("sp_ch2", out_ch, 2);
        in_valid = 4'b0010;
        #1 chk("sp_ready", in_ready, 4'b0010);
        step();
        chk("sp_ch1", out_ch, 1);
        in_valid = 4'b1111;
        step();
        chk("sp_next", out_ch, 2);

        // Mode/sel change while stalled leaves held word alone.
        out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
        step();
        chk("mc_hold_ch", out_ch, 2);
        chk("mc_hold_data", out_data, 8'h04);
        out_ready = 1'b1;
        step();
        chk("mc_new_ch", out_ch, 0);
        chk("mc_new_data", out_data, 8'h01);

        // N=5: out-of-range select grants nothing.
        chk("n5_sel7_ready", in_ready5, 0);
        chk("n5_sel7_valid", out_valid5, 0);
        sel5 = 3'd4;
        #1 chk("n5_sel4_ready", in_ready5, 5'b10000);
        step();
        chk("n5_sel4_ch", out_ch5, 4);
        chk("n5_sel4_data", out_data5, 8'h50);
        sel5 = 3'd5;
        #1 chk("n5_sel5_ready", in_ready5, 0);
        step();
        chk("n5_sel5_valid", out_valid5, 0);
        chk("n5_cnt", xfer_cnt5, cnt8 == 0 ? 0 : 1);

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
